// File: rtl/aia_msi_pkg.sv
// Shared IMSIC MSI definitions: setipnum address map, AXI response codes, MSI sender state and queue entry.
package aia_msi_pkg;
    localparam logic [31:0] IMSIC_M_BASE      = 32'h2400_0000;
    localparam logic [31:0] IMSIC_S_BASE      = 32'h2800_0000;
    localparam logic [31:0] IMSIC_FILE_STRIDE = 32'h0000_1000;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

    // Entry fields are sized for the largest supported configuration (256 files, 32-bit EIID).
    localparam int MSI_FILE_W = 8;
    localparam int MSI_EIID_W = 32;

    typedef enum logic [1:0] {IDLE, SEND, RESP} msi_tx_state_e;

    typedef struct packed {
        logic [MSI_FILE_W-1:0] file;
        logic [MSI_EIID_W-1:0] eiid;
    } msi_entry_t;

    function automatic logic [31:0] msi_addr(input logic [MSI_FILE_W-1:0] file);
        if (file == '0) return IMSIC_M_BASE;
        return IMSIC_S_BASE + (32'(file) - 32'd1) * IMSIC_FILE_STRIDE;
    endfunction
endpackage

// File: rtl/ariane_axi.sv
// AXI4 channel and bundle types for the CVA6/Ariane system bus (64-bit address/data, 10-bit ID).
package ariane_axi;
    localparam int AddrWidth = 64;
    localparam int DataWidth = 64;
    localparam int IdWidth   = 10;
    localparam int UserWidth = 1;
    localparam int StrbWidth = DataWidth / 8;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic                 lock;
        logic [3:0]           cache;
        logic [2:0]           prot;
        logic [3:0]           qos;
        logic [3:0]           region;
        logic [5:0]           atop;
        logic [UserWidth-1:0] user;
    } aw_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [StrbWidth-1:0] strb;
        logic                 last;
        logic [UserWidth-1:0] user;
    } w_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [1:0]           resp;
        logic [UserWidth-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic                 lock;
        logic [3:0]           cache;
        logic [2:0]           prot;
        logic [3:0]           qos;
        logic [3:0]           region;
        logic [UserWidth-1:0] user;
    } ar_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [DataWidth-1:0] data;
        logic [1:0]           resp;
        logic                 last;
        logic [UserWidth-1:0] user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_t;
endpackage

// File: rtl/aia_sync_fifo.sv
// Synchronous FIFO, power-of-two depth; push and pop may coincide, caller never pushes when full.
module aia_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
endmodule

// File: rtl/imsic_msi_tx.sv
// Queues (file, EIID) MSI requests and writes each as one AXI4 beat to the IMSIC setipnum register.
// Define IMSIC_MSI_TX_ERR_CNT_EN for a sticky bresp error flag and saturating error counter.
module imsic_msi_tx
    import aia_msi_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 10,
    parameter int NR_INTP_FILES  = 2,
    parameter int EIID_W         = 11,
    parameter int FIFO_DEPTH     = 4,
    parameter int TX_ID          = 0,
    localparam int FILE_W = (NR_INTP_FILES > 1) ? $clog2(NR_INTP_FILES) : 1
)(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [FILE_W-1:0] i_file,
    input  logic [EIID_W-1:0] i_eiid,
    output logic              o_drop,
    output logic              o_busy,
`ifdef IMSIC_MSI_TX_ERR_CNT_EN
    output logic              o_err,
    output logic [7:0]        o_err_cnt,
    input  logic              i_err_clr,
`endif
    output ariane_axi::req_t  o_req,
    input  ariane_axi::resp_t i_resp
);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int REQ_AW = ariane_axi::AddrWidth;
    localparam int REQ_DW = ariane_axi::DataWidth;
    localparam int REQ_IW = ariane_axi::IdWidth;
    localparam int REQ_SW = ariane_axi::StrbWidth;

    msi_entry_t          push_entry;
    msi_entry_t          head;
    msi_entry_t          hold;
    msi_tx_state_e       state;
    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic                file_ok;
    logic                accept;
    logic                aw_valid;
    logic                w_valid;
    logic                b_ready;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [AXI_DATA_WIDTH-1:0] w_data;

    assign file_ok    = 32'(i_file) < NR_INTP_FILES;
    assign accept     = i_valid && o_ready;
    assign fifo_push  = accept && file_ok;
    assign fifo_pop   = (state == IDLE) && !fifo_empty;
    assign push_entry = '{file: MSI_FILE_W'(i_file), eiid: MSI_EIID_W'(i_eiid)};
    assign o_ready    = !fifo_full;
    assign o_busy     = (state != IDLE) || (fifo_count != '0);

    aia_sync_fifo #(
        .WIDTH($bits(msi_entry_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (i_clk),
        .rst       (i_rst),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) o_drop <= 1'b0;
        else       o_drop <= accept && !file_ok;
    end

    // Each channel's valid drops on its own handshake; RESP is entered once both are retired.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            hold     <= '0;
            aw_valid <= 1'b0;
            w_valid  <= 1'b0;
            b_ready  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (!fifo_empty) begin
                    hold     <= head;
                    aw_valid <= 1'b1;
                    w_valid  <= 1'b1;
                    state    <= SEND;
                end
                SEND: begin
                    if (aw_valid && i_resp.aw_ready) aw_valid <= 1'b0;
                    if (w_valid && i_resp.w_ready)   w_valid  <= 1'b0;
                    if ((!aw_valid || i_resp.aw_ready) && (!w_valid || i_resp.w_ready)) begin
                        b_ready <= 1'b1;
                        state   <= RESP;
                    end
                end
                RESP: if (i_resp.b_valid) begin
                    b_ready <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign aw_addr = AXI_ADDR_WIDTH'(msi_addr(hold.file));
    assign w_data  = AXI_DATA_WIDTH'(hold.eiid);

    always_comb begin
        o_req          = '0;
        o_req.aw.id    = REQ_IW'(AXI_ID_WIDTH'(TX_ID));
        o_req.aw.addr  = REQ_AW'(aw_addr);
        o_req.aw.len   = 8'd0;
        o_req.aw.size  = 3'b010;
        o_req.aw.burst = AXI_BURST_INCR;
        o_req.aw_valid = aw_valid;
        o_req.w.data   = REQ_DW'(w_data);
        o_req.w.strb   = REQ_SW'(8'h0F);
        o_req.w.last   = 1'b1;
        o_req.w_valid  = w_valid;
        o_req.b_ready  = b_ready;
    end

`ifdef IMSIC_MSI_TX_ERR_CNT_EN
    logic err_hit;
    assign err_hit = (state == RESP) && i_resp.b_valid && (i_resp.b.resp != AXI_RESP_OKAY);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_err     <= 1'b0;
            o_err_cnt <= 8'd0;
        end else if (err_hit) begin
            o_err <= 1'b1;
            if (o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
        end else if (i_err_clr) begin
            o_err     <= 1'b0;
            o_err_cnt <= 8'd0;
        end
    end
`else
    logic bresp_unused;
    assign bresp_unused = ^i_resp.b.resp;
`endif

    logic resp_unused;
    assign resp_unused = ^{i_resp.ar_ready, i_resp.r_valid, i_resp.r, i_resp.b.id, i_resp.b.user};
endmodule

// File: tb/tb_imsic_msi_tx.sv
// Bench for imsic_msi_tx: vector table, directed stall/full/reset sequences and a randomized run against a queue model.
`timescale 1ns/1ps
module tb_imsic_msi_tx;
    localparam int NR = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_valid;
    logic [1:0]        i_file;
    logic [10:0]       i_eiid;
    logic              o_ready;
    logic              o_drop;
    logic              o_busy;
    ariane_axi::req_t  req;
    ariane_axi::resp_t resp = '0;
`ifdef IMSIC_MSI_TX_ERR_CNT_EN
    logic              o_err;
    logic [7:0]        o_err_cnt;
    logic              i_err_clr;
`endif

    imsic_msi_tx #(
        .AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(10),
        .NR_INTP_FILES(NR), .EIID_W(11), .FIFO_DEPTH(4), .TX_ID(0)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_file(i_file), .i_eiid(i_eiid), .o_drop(o_drop), .o_busy(o_busy),
`ifdef IMSIC_MSI_TX_ERR_CNT_EN
        .o_err(o_err), .o_err_cnt(o_err_cnt), .i_err_clr(i_err_clr),
`endif
        .o_req(req), .i_resp(resp)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model_addr(input int f);
        return (f == 0) ? 64'h2400_0000 : 64'h2800_0000 + 64'(f - 1) * 64'h1000;
    endfunction

    // Slave/monitor state: 0 = zero-wait, 1 = random readiness, 2 = AW/W stalled.
    int          slv_mode = 0;
    int          aw_stall = 0;
    int          aw_n = 0, w_n = 0, b_n = 0;
    int          cyc = 0, aw_cyc = 0, w_cyc = 0, b_cyc = 0;
    int          drop_n = 0;
    bit          b_hs_flag = 0;
    bit          aw_pend_prev = 0, w_pend_prev = 0;
    logic [63:0] aw_addr_prev, w_data_prev;
    logic [1:0]  resp_q[$];
    logic [63:0] obs_addr[$];
    logic [63:0] obs_data[$];

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            aw_n = 0; w_n = 0; b_n = 0; b_hs_flag = 0;
            aw_pend_prev = 0; w_pend_prev = 0;
            resp.aw_ready = 1'b0; resp.w_ready = 1'b0; resp.b_valid = 1'b0;
        end else begin
            if (b_hs_flag) begin
                resp.b_valid = 1'b0;
                b_hs_flag = 0;
            end
            if (!resp.b_valid && (((aw_n < w_n) ? aw_n : w_n) > b_n) &&
                (slv_mode != 1 || $urandom_range(0, 2) == 0)) begin
                resp.b_valid = 1'b1;
                resp.b.resp  = (resp_q.size() > 0) ? resp_q.pop_front() : 2'b00;
            end
            case (slv_mode)
                0:       begin resp.aw_ready = 1'b1; resp.w_ready = 1'b1; end
                1:       begin resp.aw_ready = 1'($urandom_range(0, 1)); resp.w_ready = 1'($urandom_range(0, 1)); end
                default: begin resp.aw_ready = 1'b0; resp.w_ready = 1'b0; end
            endcase
            if (aw_stall > 0) begin
                resp.aw_ready = 1'b0;
                if (req.aw_valid) aw_stall--;
            end
            if (aw_pend_prev && req.aw_valid) chk("aw_addr_stable", req.aw.addr, aw_addr_prev);
            if (w_pend_prev && req.w_valid)   chk("w_data_stable", req.w.data, w_data_prev);
            if (req.b_ready) chk("b_ready_outside_send", {req.aw_valid, req.w_valid}, 0);
            if (req.aw_valid && resp.aw_ready) begin
                aw_n++;
                aw_cyc = cyc;
                obs_addr.push_back(req.aw.addr);
                chk("aw_fields", {req.aw.id, req.aw.len, req.aw.size, req.aw.burst, req.aw.lock,
                                  req.aw.cache, req.aw.prot, req.aw.qos, req.aw.region, req.aw.atop},
                    {10'd0, 8'd0, 3'b010, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 6'd0});
                chk("read_idle", {req.ar_valid, req.r_ready}, 0);
            end
            if (req.w_valid && resp.w_ready) begin
                w_n++;
                w_cyc = cyc;
                obs_data.push_back(req.w.data);
                chk("w_fields", {req.w.strb, req.w.last}, {8'h0F, 1'b1});
            end
            aw_pend_prev = req.aw_valid && !resp.aw_ready;
            w_pend_prev  = req.w_valid && !resp.w_ready;
            aw_addr_prev = req.aw.addr;
            w_data_prev  = req.w.data;
            if (resp.b_valid && req.b_ready) begin
                b_n++;
                b_cyc = cyc;
                b_hs_flag = 1;
            end
            if (o_drop) drop_n++;
        end
    end

    task automatic push(input logic [1:0] f, input logic [10:0] e);
        @(negedge clk);
        i_valid = 1'b1; i_file = f; i_eiid = e;
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int cycles);
        cycles = 0;
        while (o_busy && cycles < budget) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (o_busy) begin
            n_chk++; n_fail++;
            $display("FAIL idle_timeout: busy still 1 after %0d cycles, expected 0", budget);
        end
    endtask

    typedef struct {
        logic [1:0]  file;
        logic [10:0] eiid;
        logic [63:0] addr;
        logic [63:0] data;
        logic        drop;
    } vec_t;
    vec_t vt[6];

    logic [63:0] exp_addr[$];
    logic [63:0] exp_data[$];

    initial begin
        int n0, d0, b0, lat, k, mdrop, f, e;
        bit acc;

        vt[0] = '{2'd0, 11'h005, 64'h2400_0000, 64'h005, 1'b0};
        vt[1] = '{2'd1, 11'h7FF, 64'h2800_0000, 64'h7FF, 1'b0};
        vt[2] = '{2'd2, 11'h003, 64'h2800_1000, 64'h003, 1'b0};
        vt[3] = '{2'd3, 11'h012, 64'h0,         64'h0,   1'b1};
        vt[4] = '{2'd2, 11'h400, 64'h2800_1000, 64'h400, 1'b0};
        vt[5] = '{2'd0, 11'h000, 64'h2400_0000, 64'h000, 1'b0};

        rst = 1'b1; i_valid = 1'b0; i_file = '0; i_eiid = '0;
`ifdef IMSIC_MSI_TX_ERR_CNT_EN
        i_err_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", o_ready, 1);
        chk("rst_drop", o_drop, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_valids", {req.aw_valid, req.w_valid, req.ar_valid}, 0);
        chk("rst_readies", {req.b_ready, req.r_ready}, 0);
`ifdef IMSIC_MSI_TX_ERR_CNT_EN
        chk("rst_err", {o_err, o_err_cnt}, 0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            n0 = obs_addr.size();
            d0 = drop_n;
            @(negedge clk);
            i_valid = 1'b1; i_file = vt[i].file; i_eiid = vt[i].eiid;
            chk("vec_ready", o_ready, 1);
            @(posedge clk); #1;
            i_valid = 1'b0;
            chk("vec_drop_pulse", o_drop, vt[i].drop);
            chk("vec_busy", o_busy, !vt[i].drop);
            if (vt[i].drop) begin
                repeat (4) @(posedge clk);
                #1;
                chk("drop_no_traffic", obs_addr.size(), n0);
                chk("drop_cleared", o_drop, 0);
                chk("drop_busy", o_busy, 0);
                chk("drop_one_pulse", drop_n - d0, 1);
            end else begin
                wait_idle(20, lat);
                chk("vec_latency", lat, 3);
                chk("vec_aw_count", obs_addr.size(), n0 + 1);
                if (obs_addr.size() > n0) begin
                    chk("vec_aw_addr", obs_addr[n0], vt[i].addr);
                    chk("vec_w_data", obs_data[n0], vt[i].data);
                end
                chk("vec_ready_after", o_ready, 1);
            end
        end

        // AW held off for 5 cycles while W is accepted immediately.
        n0 = obs_addr.size();
        b0 = b_n;
        aw_stall = 5;
        push(2'd1, 11'h0AB);
        wait_idle(40, lat);
        chk("stall_latency", lat, 8);
        chk("stall_aw_count", obs_addr.size(), n0 + 1);
        if (obs_addr.size() > n0) begin
            chk("stall_addr", obs_addr[n0], 64'h2800_0000);
            chk("stall_data", obs_data[n0], 64'h0AB);
        end
        chk("stall_w_before_aw", w_cyc < aw_cyc, 1);
        chk("stall_b_after_both", b_cyc > aw_cyc, 1);
        chk("stall_single_b", b_n - b0, 1);

        // Stalled slave: four queued plus one held, then backpressure.
        slv_mode = 2;
        n0 = obs_addr.size();
        k = 0;
        for (int c = 0; c < 12 && k < 6; c++) begin
            @(negedge clk);
            i_valid = 1'b1; i_file = 2'(k % 3); i_eiid = 11'(16 + k);
            acc = o_ready;
            @(posedge clk);
            if (acc) k++;
        end
        #1;
        chk("full_accepted", k, 5);
        chk("full_ready_low", o_ready, 0);
        chk("full_busy", o_busy, 1);
        slv_mode = 0;
        for (int c = 0; c < 40 && k < 6; c++) begin
            @(negedge clk);
            i_valid = 1'b1; i_file = 2'(k % 3); i_eiid = 11'(16 + k);
            acc = o_ready;
            @(posedge clk);
            if (acc) k++;
        end
        #1;
        i_valid = 1'b0;
        chk("full_sixth_accepted", k, 6);
        wait_idle(100, lat);
        chk("full_delivered", obs_addr.size(), n0 + 6);
        for (int j = 0; j < 6; j++) begin
            if (obs_addr.size() > n0 + j) begin
                chk("full_order_addr", obs_addr[n0 + j], model_addr(j % 3));
                chk("full_order_data", obs_data[n0 + j], 64'(16 + j));
            end
        end

        // Randomized traffic against the queue model.
        slv_mode = 1;
        n0 = obs_addr.size();
        d0 = drop_n;
        mdrop = 0;
        exp_addr.delete();
        exp_data.delete();
        for (int j = 0; j < 40; j++) begin
            f = $urandom_range(0, 3);
            e = $urandom_range(0, 2047);
            @(negedge clk);
            i_valid = 1'b1; i_file = 2'(f); i_eiid = 11'(e);
            for (int w = 0; w < 200 && !o_ready; w++) @(negedge clk);
            if (!o_ready) begin
                n_chk++; n_fail++;
                $display("FAIL rand_ready_timeout: ready 0, expected 1");
            end
            @(posedge clk); #1;
            i_valid = 1'b0;
            if (f < NR) begin
                exp_addr.push_back(model_addr(f));
                exp_data.push_back(64'(e));
            end else begin
                mdrop++;
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        wait_idle(2000, lat);
        repeat (2) @(posedge clk);
        #1;
        chk("rand_count", obs_addr.size() - n0, exp_addr.size());
        chk("rand_w_count", obs_data.size() - n0, exp_data.size());
        chk("rand_drops", drop_n - d0, mdrop);
        for (int j = 0; j < exp_addr.size(); j++) begin
            if (obs_addr.size() > n0 + j) begin
                chk("rand_addr", obs_addr[n0 + j], exp_addr[j]);
                chk("rand_data", obs_data[n0 + j], exp_data[j]);
            end
        end

`ifdef IMSIC_MSI_TX_ERR_CNT_EN
        slv_mode = 0;
        resp_q.push_back(2'b10);
        resp_q.push_back(2'b00);
        resp_q.push_back(2'b11);
        for (int j = 0; j < 3; j++) begin
            push(2'd0, 11'(j));
            wait_idle(20, lat);
        end
        chk("err_flag", o_err, 1);
        chk("err_cnt", o_err_cnt, 2);
        @(negedge clk);
        i_err_clr = 1'b1;
        @(posedge clk); #1;
        i_err_clr = 1'b0;
        chk("err_clr", {o_err, o_err_cnt}, 0);
`endif

        // Reset while a write is outstanding.
        slv_mode = 2;
        push(2'd0, 11'd1);
        push(2'd1, 11'd2);
        push(2'd2, 11'd3);
        for (int c = 0; c < 20 && !req.aw_valid; c++) begin
            @(posedge clk); #1;
        end
        chk("mid_send_aw_valid", req.aw_valid, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_valids", {req.aw_valid, req.w_valid, req.b_ready}, 0);
        chk("rst_mid_busy", o_busy, 0);
        chk("rst_mid_ready", o_ready, 1);
        rst = 1'b0;
        slv_mode = 0;
        n0 = obs_addr.size();
        repeat (10) @(posedge clk);
        #1;
        chk("rst_mid_fifo_empty", obs_addr.size(), n0);
        chk("rst_mid_idle", o_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
